// File: rtl/xpb_accum_pkg.sv
// xpb_accum_pkg: shared sizes and FSM state codes for the XPB accumulator
package xpb_accum_pkg;
  localparam int WIDTH = 1024;
  localparam int MAX_TERMS = 64;
  localparam int GUARD = 7;
  localparam int LIMB = 64;
  localparam int SW = WIDTH + GUARD;
  localparam int NLIMB = (SW + LIMB - 1) / LIMB;
  localparam int PW = NLIMB * LIMB;
  localparam int CW = 7;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t RESOLVE = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/xpb_csa3.sv
// xpb_csa3: bitwise 3:2 carry-save compressor
module xpb_csa3
  import xpb_accum_pkg::*;
(
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic [SW-1:0] d,
  output logic [SW-1:0] s,
  output logic [SW-1:0] c
);
  assign s = a ^ b ^ d;
  assign c = (a & b) | (a & d) | (b & d);
endmodule

// File: rtl/xpb_accum.sv
// xpb_accum: carry-save sum of XPB terms, limb-serial carry resolve, valid/ready result
module xpb_accum
  import xpb_accum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_data,
  output logic [CW-1:0]    out_count,
  output logic             err
);
  state_t state;
  logic [PW-1:0] s, cp, rp;
  logic [SW-1:0] c, ext, cs_s, cs_c;
  logic [CW-1:0] cnt;
  logic [4:0] idx;
  logic cin, cout;
  logic [LIMB-1:0] limb;
  assign ext = SW'(in_data);
  assign cp = PW'({c, 1'b0});
  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign out_valid = state == DONE;
  assign out_count = cnt;
  xpb_csa3 u_csa (.a(s[SW-1:0]), .b(cp[SW-1:0]), .d(ext), .s(cs_s), .c(cs_c));
  // Resolved limbs overwrite S in place; each limb of S is read exactly once.
  always_comb begin
    {cout, limb} = {1'b0, s[idx*LIMB +: LIMB]} + {1'b0, cp[idx*LIMB +: LIMB]} + (LIMB+1)'(cin);
    rp = s;
    rp[idx*LIMB +: LIMB] = limb;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      c <= '0;
      cnt <= '0;
      idx <= '0;
      cin <= 1'b0;
      out_data <= '0;
      err <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          idx <= '0;
          cin <= 1'b0;
          if (in_valid) begin
            if (in_first) begin
              s <= PW'(in_data);
              c <= '0;
              cnt <= CW'(1);
              state <= in_last ? RESOLVE : ACCUM;
            end else if (state == IDLE) begin
              err <= 1'b1;
            end else begin
              s <= PW'(cs_s);
              c <= cs_c;
              cnt <= cnt + CW'(1);
              if (in_last || cnt == CW'(MAX_TERMS)) state <= RESOLVE;
              if (cnt == CW'(MAX_TERMS)) err <= 1'b1;
            end
          end
        end
        RESOLVE: begin
          if (idx == 5'(NLIMB)) begin
            out_data <= s[SW-1:0];
            state <= DONE;
          end else begin
            s <= rp;
            cin <= cout;
            idx <= idx + 5'd1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xpb_accum.sv
// tb_xpb_accum: randomized scoreboard bench for xpb_accum against an arithmetic reference
module tb_xpb_accum;
  import xpb_accum_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, in_first = 0, in_last = 0, out_ready = 0, hold = 1;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid, err;
  logic [SW-1:0] out_data;
  logic [CW-1:0] out_count;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [SW-1:0] d; int n; logic e; int acc;} exp_t;
  exp_t sb[$];
  logic [SW-1:0] m_sum = '0;
  int m_cnt = 0;
  logic m_open = 0, m_err = 0, prev_ov = 0;
  logic [WIDTH-1:0] ones, top;

  xpb_accum dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h..%h exp=%h..%h", nm, got[SW-1:SW-64], got[63:0], exp[SW-1:SW-64], exp[63:0]);
    end
  endtask

  // Reference: a result is the plain sum of every term since the last first beat.
  task automatic model(input logic f, input logic l, input logic [WIDTH-1:0] d);
    if (f) begin
      m_sum = SW'(d);
      m_cnt = 1;
      m_open = !l;
    end else if (!m_open) begin
      m_err = 1;
      return;
    end else begin
      m_sum = m_sum + SW'(d);
      m_cnt++;
      if (m_cnt > MAX_TERMS) m_err = 1;
      if (m_cnt > MAX_TERMS) l = 1;
      if (l) m_open = 0;
    end
    if (l) sb.push_back('{m_sum, m_cnt, m_err, cyc + 1});
  endtask

  task automatic beat(input logic f, input logic l, input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_first = f; in_last = l; in_data = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout in_ready=%b", in_ready);
    end else model(f, l, d);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_ov && sb.size() != 0) chk("latency", SW'(cyc - sb[0].acc), SW'(18));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output out_data_lo=%h expected none", out_data[63:0]);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_count", SW'(out_count), SW'(e.n));
          chk("err", SW'(err), SW'(e.e));
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ones = '1;
    top = '0;
    top[WIDTH-1] = 1'b1;
    #12;
    chk("rst_in_ready", SW'(in_ready), SW'(1));
    chk("rst_out_valid", SW'(out_valid), SW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_count", SW'(out_count), SW'(0));
    chk("rst_err", SW'(err), SW'(0));
    @(negedge clk);
    rst = 0;
    hold = 0;
    beat(1, 1, WIDTH'(5));
    beat(1, 0, top); beat(0, 0, top); beat(0, 1, top);
    beat(1, 0, WIDTH'(7)); beat(0, 0, WIDTH'(9)); beat(1, 0, WIDTH'(11)); beat(0, 1, WIDTH'(13));
    idle();
    drain();
    hold = 1;
    beat(1, 1, WIDTH'(42));
    idle();
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    in_valid = 1; in_first = 1; in_last = 1; in_data = WIDTH'(99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, SW'(42));
      chk("stall_in_ready", SW'(in_ready), SW'(0));
      chk("stall_valid", SW'(out_valid), SW'(1));
    end
    in_valid = 0; in_first = 0; in_last = 0;
    hold = 0;
    drain();
    for (int op = 0; op < 25; op++) begin
      int len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        beat(k == 0 || $urandom_range(0, 9) == 0, k == len - 1, ($urandom_range(0, 7) == 0) ? ones : rnd());
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    drain();
    chk("no_err_yet", SW'(err), SW'(0));
    beat(1, 0, ones);
    for (int k = 0; k < 62; k++) beat(0, 0, ones);
    beat(0, 1, ones);
    beat(1, 0, ones);
    for (int k = 0; k < 64; k++) beat(0, 0, ones);
    idle();
    drain();
    chk("overflow_err", SW'(err), SW'(1));
    beat(1, 0, WIDTH'(100)); beat(0, 1, WIDTH'(200));
    idle();
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", SW'(out_valid), SW'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_out_count", SW'(out_count), SW'(0));
    chk("arst_err", SW'(err), SW'(0));
    chk("arst_in_ready", SW'(in_ready), SW'(1));
    sb.delete();
    m_open = 0;
    m_err = 0;
    @(negedge clk);
    rst = 0;
    beat(1, 0, WIDTH'(1)); beat(0, 1, WIDTH'(2));
    idle();
    drain();
    beat(0, 1, WIDTH'(5));
    idle();
    @(negedge clk);
    chk("proto_err", SW'(err), SW'(1));
    chk("proto_in_ready", SW'(in_ready), SW'(1));
    beat(1, 1, WIDTH'(6));
    idle();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
